// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB transmit scheduler.
// PIDs, FSM state and requester-source encodings, plus a max helper for counter sizing.
package usb_tx_pkg;

  localparam logic [7:0] PID_OUT   = 8'hE1;
  localparam logic [7:0] PID_IN    = 8'h69;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;

  typedef enum logic [2:0] {IDLE, LOAD, SEND, EOP, GAP} tx_state_t;

  typedef enum logic [1:0] {SRC_HS, SRC_TOK, SRC_DAT} src_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/usb_tx_scheduler_if.sv
// Requester, encoder-chain and status signals of the USB transmit scheduler.
// slave = scheduler side; master = requesters plus the encoder/stuffer chain.
interface usb_tx_scheduler_if;
  logic        hs_req;
  logic [7:0]  hs_pid;
  logic        hs_gnt;
  logic        tok_req;
  logic [7:0]  tok_pid;
  logic [6:0]  tok_addr;
  logic [3:0]  tok_endp;
  logic        tok_gnt;
  logic        dat_req;
  logic [7:0]  dat_pid;
  logic [63:0] dat_data;
  logic        dat_gnt;
  logic        pkt_avail;
  logic [7:0]  pid_in;
  logic [6:0]  addr_in;
  logic [3:0]  endp_in;
  logic [63:0] data_in;
  logic        stall;
  logic        last;
  logic        eop_se0;
  logic        busy;
  logic        done;
  logic        abort;

  modport slave (
    input  hs_req, hs_pid, tok_req, tok_pid, tok_addr, tok_endp,
           dat_req, dat_pid, dat_data, stall, last,
    output hs_gnt, tok_gnt, dat_gnt, pkt_avail, pid_in, addr_in, endp_in,
           data_in, eop_se0, busy, done, abort
  );

  modport master (
    output hs_req, hs_pid, tok_req, tok_pid, tok_addr, tok_endp,
           dat_req, dat_pid, dat_data, stall, last,
    input  hs_gnt, tok_gnt, dat_gnt, pkt_avail, pid_in, addr_in, endp_in,
           data_in, eop_se0, busy, done, abort
  );
endinterface

// File: rtl/usb_tx_prio_pick.sv
// Combinational fixed-priority picker over {dat, tok, hs}; hs highest.
// Zero latency; no backpressure.
module usb_tx_prio_pick
  import usb_tx_pkg::*;
(
  input  logic [2:0] i_cand,
  output logic [2:0] o_onehot,
  output src_t       o_src,
  output logic       o_any
);

  always_comb begin
    o_onehot = 3'b000;
    o_src    = SRC_HS;
    if (i_cand[0]) begin
      o_onehot = 3'b001;
      o_src    = SRC_HS;
    end else if (i_cand[1]) begin
      o_onehot = 3'b010;
      o_src    = SRC_TOK;
    end else if (i_cand[2]) begin
      o_onehot = 3'b100;
      o_src    = SRC_DAT;
    end
  end

  assign o_any = |i_cand;

endmodule

// File: rtl/usb_tx_scheduler.sv
// Arbitrates hs/tok/dat requesters and sequences one packet at a time: IDLE->LOAD->SEND->EOP->GAP.
// Grant one cycle after the request is seen in IDLE; SEND holds while stalled. Timeout: USB_TX_TIMEOUT_EN.
module usb_tx_scheduler
  import usb_tx_pkg::*;
#(
  parameter int EOP_BITS       = 2,
  parameter int IPG_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 128
) (
  input  logic                clk,
  input  logic                rst,
  usb_tx_scheduler_if.slave   bus
);

  localparam int CNT_W = $clog2(max3(EOP_BITS, IPG_CYCLES, TIMEOUT_CYCLES) + 1);
  localparam logic [CNT_W-1:0] EOP_LD = CNT_W'(EOP_BITS - 1);
  localparam logic [CNT_W-1:0] GAP_LD = CNT_W'(IPG_CYCLES - 1);
`ifdef USB_TX_TIMEOUT_EN
  localparam logic [CNT_W-1:0] SEND_LD = CNT_W'(TIMEOUT_CYCLES);
`else
  localparam logic [CNT_W-1:0] SEND_LD = '0;
`endif

  tx_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  src_t             r_src;
  logic [7:0]       r_pid;
  logic [6:0]       r_addr;
  logic [3:0]       r_endp;
  logic [63:0]      r_data;
  logic [2:0]       r_pend;
  logic             r_done;
  logic             r_abort;

  logic [2:0]       w_req, w_pend_live, w_cand, w_onehot;
  src_t             w_src;
  logic             w_any;
  logic             w_load;
  logic             w_timeout;

  assign w_req       = {bus.dat_req, bus.tok_req, bus.hs_req};
  // Losers of the previous arbitration go first, so a later higher-priority request cannot starve them.
  assign w_pend_live = r_pend & w_req;
  assign w_cand      = (|w_pend_live) ? w_pend_live : w_req;

  usb_tx_prio_pick u_pick (
    .i_cand   (w_cand),
    .o_onehot (w_onehot),
    .o_src    (w_src),
    .o_any    (w_any)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_timeout   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt = LOAD;
          w_load      = 1'b1;
        end
      end
      LOAD: begin
        w_state_nxt = SEND;
        w_cnt_nxt   = SEND_LD;
      end
      SEND: begin
        if (bus.last && !bus.stall) begin
          w_state_nxt = EOP;
          w_cnt_nxt   = EOP_LD;
        end
`ifdef USB_TX_TIMEOUT_EN
        else if (!bus.stall) begin
          if (r_cnt <= CNT_W'(1)) begin
            w_timeout   = 1'b1;
            w_state_nxt = EOP;
            w_cnt_nxt   = EOP_LD;
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
`endif
      end
      EOP: begin
        if (r_cnt == '0) begin
          w_state_nxt = GAP;
          w_cnt_nxt   = GAP_LD;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      GAP: begin
        if (r_cnt == '0) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_abort <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= (r_state == GAP) && (w_state_nxt == IDLE);
      r_abort <= w_timeout;
    end
  end

  // Fields not belonging to the winner are forced to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_src  <= SRC_HS;
      r_pid  <= '0;
      r_addr <= '0;
      r_endp <= '0;
      r_data <= '0;
      r_pend <= '0;
    end else if (w_load) begin
      r_src  <= w_src;
      r_pend <= w_cand & ~w_onehot;
      r_addr <= '0;
      r_endp <= '0;
      r_data <= '0;
      case (w_src)
        SRC_HS:  r_pid <= bus.hs_pid;
        SRC_TOK: begin
          r_pid  <= bus.tok_pid;
          r_addr <= bus.tok_addr;
          r_endp <= bus.tok_endp;
        end
        default: begin
          r_pid  <= bus.dat_pid;
          r_data <= bus.dat_data;
        end
      endcase
    end
  end

  assign bus.hs_gnt    = (r_state == LOAD) && (r_src == SRC_HS);
  assign bus.tok_gnt   = (r_state == LOAD) && (r_src == SRC_TOK);
  assign bus.dat_gnt   = (r_state == LOAD) && (r_src == SRC_DAT);
  assign bus.pkt_avail = (r_state == LOAD);
  assign bus.pid_in    = r_pid;
  assign bus.addr_in   = r_addr;
  assign bus.endp_in   = r_endp;
  assign bus.data_in   = r_data;
  assign bus.eop_se0   = (r_state == EOP);
  assign bus.busy      = (r_state != IDLE);
  assign bus.done      = r_done;
`ifdef USB_TX_TIMEOUT_EN
  assign bus.abort     = r_abort;
`else
  assign bus.abort     = 1'b0;
`endif

endmodule

// File: tb/tb_usb_tx_scheduler.sv
// Directed bench for usb_tx_scheduler (EOP_BITS=2, IPG_CYCLES=4, TIMEOUT_CYCLES=16).
module tb_usb_tx_scheduler;
  import usb_tx_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  usb_tx_scheduler_if bus ();

  usb_tx_scheduler #(
    .EOP_BITS       (2),
    .IPG_CYCLES     (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called in a SEND cycle: raise last, then walk 2 EOP + 4 GAP cycles to the done cycle.
  task automatic finish_pkt(input string tag);
    bus.last = 1'b1;
    step();
    bus.last = 1'b0;
    check({tag, "_eop1"}, 64'(bus.eop_se0), 64'd1);
    step();
    check({tag, "_eop2"}, 64'(bus.eop_se0), 64'd1);
    step();
    check({tag, "_gap_eop"}, 64'(bus.eop_se0), 64'd0);
    check({tag, "_gap_busy"}, 64'(bus.busy), 64'd1);
    step(3);
    check({tag, "_gap4_busy"}, 64'(bus.busy), 64'd1);
    check({tag, "_gap4_done"}, 64'(bus.done), 64'd0);
    step();
    check({tag, "_done"}, 64'(bus.done), 64'd1);
    check({tag, "_idle"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.hs_req = 0; bus.hs_pid = 0;
    bus.tok_req = 0; bus.tok_pid = 0; bus.tok_addr = 0; bus.tok_endp = 0;
    bus.dat_req = 0; bus.dat_pid = 0; bus.dat_data = 0;
    bus.stall = 0; bus.last = 0;
    step(2);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_outs", 64'({bus.pkt_avail, bus.eop_se0, bus.done, bus.abort,
                           bus.hs_gnt, bus.tok_gnt, bus.dat_gnt}), 64'd0);
    check("rst_fields", 64'({bus.pid_in, bus.addr_in, bus.endp_in}), 64'd0);
    check("rst_data", bus.data_in, 64'd0);
    rst = 1'b0;
    step();

    // 1: single token packet
    bus.tok_req = 1; bus.tok_pid = PID_OUT; bus.tok_addr = 7'd5; bus.tok_endp = 4'd4;
    step();
    check("t1_gnt", 64'({bus.hs_gnt, bus.tok_gnt, bus.dat_gnt}), 64'b010);
    check("t1_pkt_avail", 64'(bus.pkt_avail), 64'd1);
    check("t1_pid", 64'(bus.pid_in), 64'hE1);
    check("t1_addr", 64'(bus.addr_in), 64'd5);
    check("t1_endp", 64'(bus.endp_in), 64'd4);
    check("t1_data", bus.data_in, 64'd0);
    bus.tok_req = 0;
    step();
    check("t1_send_pa", 64'({bus.pkt_avail, bus.tok_gnt}), 64'd0);
    finish_pkt("t1");
    step();
    check("t1_done_fall", 64'(bus.done), 64'd0);

    // 2: simultaneous requests; later hs must wait behind pending dat
    bus.hs_req = 1; bus.hs_pid = PID_ACK;
    bus.tok_req = 1; bus.tok_pid = PID_OUT; bus.tok_addr = 7'd3; bus.tok_endp = 4'd1;
    bus.dat_req = 1; bus.dat_pid = PID_DATA1; bus.dat_data = 64'h0123456789ABCDEF;
    step();
    check("t2a_gnt", 64'({bus.hs_gnt, bus.tok_gnt, bus.dat_gnt}), 64'b100);
    check("t2a_pid", 64'(bus.pid_in), 64'hD2);
    check("t2a_zero", 64'({bus.addr_in, bus.endp_in}) | bus.data_in, 64'd0);
    bus.hs_req = 0;
    step();
    finish_pkt("t2a");
    step();
    check("t2b_gnt", 64'({bus.hs_gnt, bus.tok_gnt, bus.dat_gnt}), 64'b010);
    check("t2b_fields", 64'({bus.pid_in, bus.addr_in, bus.endp_in}), 64'({8'hE1, 7'd3, 4'd1}));
    check("t2b_data", bus.data_in, 64'd0);
    bus.tok_req = 0;
    step();
    bus.hs_req = 1; bus.hs_pid = PID_NAK;
    finish_pkt("t2b");
    step();
    check("t2c_gnt", 64'({bus.hs_gnt, bus.tok_gnt, bus.dat_gnt}), 64'b001);
    check("t2c_pid", 64'(bus.pid_in), 64'h4B);
    check("t2c_data", bus.data_in, 64'h0123456789ABCDEF);
    bus.dat_req = 0;
    step();
    finish_pkt("t2c");
    step();
    check("t2d_gnt", 64'({bus.hs_gnt, bus.tok_gnt, bus.dat_gnt}), 64'b100);
    check("t2d_pid", 64'(bus.pid_in), 64'h5A);
    bus.hs_req = 0;
    step();
    finish_pkt("t2d");
    step();

    // 3: last held under stall
    bus.dat_req = 1; bus.dat_pid = PID_DATA0; bus.dat_data = 64'hCAFEBABEDEADBEEF;
    step();
    check("t3_gnt", 64'(bus.dat_gnt), 64'd1);
    bus.dat_req = 0;
    step();
    bus.stall = 1; bus.last = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t3_stall_eop", 64'(bus.eop_se0), 64'd0);
      check("t3_stall_data", bus.data_in, 64'hCAFEBABEDEADBEEF);
    end
    bus.stall = 0;
    finish_pkt("t3");
    check("t3_data_done", bus.data_in, 64'hCAFEBABEDEADBEEF);
    check("t3_pid_done", 64'(bus.pid_in), 64'hC3);
    step();

    // 4: reset mid-SEND, held dat_req re-granted
    bus.dat_req = 1; bus.dat_pid = PID_DATA1; bus.dat_data = 64'h1122334455667788;
    step();
    check("t4_gnt", 64'(bus.dat_gnt), 64'd1);
    step(2);
    rst = 1'b1;
    #1;
    check("t4_rst_busy", 64'(bus.busy), 64'd0);
    check("t4_rst_data", bus.data_in, 64'd0);
    check("t4_rst_pid", 64'(bus.pid_in), 64'd0);
    check("t4_rst_ctl", 64'({bus.pkt_avail, bus.eop_se0, bus.dat_gnt}), 64'd0);
    step(2);
    rst = 1'b0;
    check("t4_rel_gnt", 64'(bus.dat_gnt), 64'd0);
    step();
    check("t4_regnt", 64'(bus.dat_gnt), 64'd1);
    check("t4_regnt_data", bus.data_in, 64'h1122334455667788);
    bus.dat_req = 0;
    step();
    finish_pkt("t4");
    step();

    // 5: token raised during GAP
    bus.hs_req = 1; bus.hs_pid = PID_ACK;
    step();
    bus.hs_req = 0;
    step();
    bus.last = 1;
    step();
    bus.last = 0;
    step(2);
    bus.tok_req = 1; bus.tok_pid = PID_IN; bus.tok_addr = 7'd9; bus.tok_endp = 4'd2;
    check("t5_gap1_gnt", 64'(bus.tok_gnt), 64'd0);
    step(3);
    check("t5_gap4_gnt", 64'(bus.tok_gnt), 64'd0);
    step();
    check("t5_idle_done", 64'(bus.done), 64'd1);
    check("t5_idle_gnt", 64'({bus.tok_gnt, bus.pkt_avail}), 64'd0);
    step();
    check("t5_gnt", 64'({bus.tok_gnt, bus.pkt_avail}), 64'b11);
    check("t5_fields", 64'({bus.pid_in, bus.addr_in, bus.endp_in}), 64'({8'h69, 7'd9, 4'd2}));
    bus.tok_req = 0;
    step();
    finish_pkt("t5");
    step();

    // 6: last never arrives
    bus.dat_req = 1; bus.dat_pid = PID_DATA0; bus.dat_data = 64'd0;
    step();
    bus.dat_req = 0;
    step();
    bus.stall = 1;
    step(3);
    bus.stall = 0;
`ifdef USB_TX_TIMEOUT_EN
    step(15);
    check("t6_pre_abort", 64'({bus.abort, bus.eop_se0}), 64'd0);
    step();
    check("t6_abort", 64'({bus.abort, bus.eop_se0}), 64'b11);
    step();
    check("t6_abort_fall", 64'({bus.abort, bus.eop_se0}), 64'b01);
    step(5);
    check("t6_done", 64'({bus.done, bus.busy}), 64'b10);
`else
    step(20);
    check("t6_busy", 64'(bus.busy), 64'd1);
    check("t6_no_abort", 64'({bus.abort, bus.eop_se0}), 64'd0);
    finish_pkt("t6");
`endif
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
